// File: rtl/netlist_bist_ctrl.sv
// BIST controller: drives LFSR stimulus into a netlist under test and compacts its
// single-bit response into a CRC-style signature compared against an expected value.
module netlist_bist_ctrl #(
    parameter int N_IN  = 11,
    parameter int LAT   = 1,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      pat_count,
    input  logic [N_IN-1:0]  seed,
    input  logic [SIG_W-1:0] exp_sig,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021);
    localparam logic [LAT-1:0]   VLD_ONE  = LAT'(1'b1);

    // Fibonacci LFSR step; for N_IN=11 this is x^11 + x^9 + 1.
    function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] cur);
        return {cur[N_IN-2:0], cur[N_IN-1] ^ cur[N_IN-3]};
    endfunction

    // Serial CRC-style compaction of one response bit.
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] cur,
                                                  input logic              bit_in);
        logic fb;
        fb = cur[SIG_W-1] ^ bit_in;
        return {cur[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : {SIG_W{1'b0}});
    endfunction

    logic [1:0]       state_r;
    logic [15:0]      remain_r;
    logic [SIG_W-1:0] exp_r;
    logic [LAT-1:0]   vld_r;
    logic [N_IN-1:0]  dut_in_r;
    logic [SIG_W-1:0] sig_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic             push_s;
    logic             sample_s;
    logic [LAT-1:0]   vld_next_s;
    logic [SIG_W-1:0] sig_next_s;

    // Response pipeline advance and signature update for the current cycle.
    always_comb begin
        push_s     = (state_r == S_RUN);
        sample_s   = vld_r[LAT-1];
        vld_next_s = (vld_r << 1) | LAT'(push_s);
        if (sample_s) begin
            sig_next_s = sig_step(sig_r, dut_out);
        end else begin
            sig_next_s = sig_r;
        end
    end

    // Main controller FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            remain_r <= 16'd0;
            exp_r    <= '0;
            vld_r    <= '0;
            dut_in_r <= '0;
            sig_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !abort) begin
                        dut_in_r <= (seed == '0) ? N_IN'(1'b1) : seed;
                        sig_r    <= '0;
                        exp_r    <= exp_sig;
                        remain_r <= pat_count - 16'd1;
                        if (pat_count == 16'd0) begin
                            // Nothing to apply: report immediately against a zero signature.
                            state_r <= S_DONE;
                            vld_r   <= '0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (exp_sig == '0);
                        end else begin
                            state_r <= (pat_count == 16'd1) ? S_DRAIN : S_RUN;
                            vld_r   <= VLD_ONE;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                            pass_r  <= 1'b0;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                        vld_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else begin
                        dut_in_r <= lfsr_next(dut_in_r);
                        vld_r    <= vld_next_s;
                        sig_r    <= sig_next_s;
                        remain_r <= remain_r - 16'd1;
                        if (remain_r == 16'd1) begin
                            state_r <= S_DRAIN;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_r <= S_IDLE;
                        vld_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else begin
                        vld_r <= vld_next_s;
                        sig_r <= sig_next_s;
                        if (vld_next_s == '0) begin
                            // Last response captured this edge; judge the final signature.
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (sig_next_s == exp_r);
                        end else begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    if (abort) begin
                        pass_r <= 1'b0;
                    end else begin
                        pass_r <= pass_r;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    vld_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in    = dut_in_r;
    assign signature = sig_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Directed bench for netlist_bist_ctrl (default parameters, LAT=1) with
// hand-computed signatures and cycle-exact done/busy timing.
module tb_netlist_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pat_count = 16'd0;
    logic [10:0] seed = 11'd0;
    logic [15:0] exp_sig = 16'd0;
    logic [10:0] dut_in;
    logic        dut_out = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;

    netlist_bist_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pat_count (pat_count),
        .seed      (seed),
        .exp_sig   (exp_sig),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply start for exactly one edge (T0); returns just after T0.
    task automatic launch(input logic [10:0] s, input logic [15:0] n, input logic [15:0] e);
        seed      = s;
        pat_count = n;
        exp_sig   = e;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            got = done;
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    initial begin
        logic saw_done;
        int   k;

        // Reset state
        tick();
        chk("rst_dut_in", {21'd0, dut_in}, 32'h0);
        chk("rst_sig", {16'd0, signature}, 32'h0);
        chk("rst_flags", {29'd0, busy, done, pass}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Seed 1: LFSR shift sequence and done timing for 4 patterns
        dut_out = 1'b0;
        launch(11'h001, 16'd4, 16'h0000);
        chk("seq1_p0", {21'd0, dut_in}, 32'h001);
        chk("seq1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("seq1_p1", {21'd0, dut_in}, 32'h002);
        tick();
        chk("seq1_p2", {21'd0, dut_in}, 32'h004);
        tick();
        chk("seq1_p3", {21'd0, dut_in}, 32'h008);
        chk("seq1_busy_drain", {31'd0, busy}, 32'd1);
        tick();
        chk("seq1_done", {29'd0, busy, done, pass}, 32'b011);
        chk("seq1_hold", {21'd0, dut_in}, 32'h008);
        tick();
        chk("seq1_after", {29'd0, busy, done, pass}, 32'b001);

        // Seed 0 maps to 1
        launch(11'h000, 16'd3, 16'h0000);
        chk("seq0_p0", {21'd0, dut_in}, 32'h001);
        tick();
        chk("seq0_p1", {21'd0, dut_in}, 32'h002);
        tick();
        chk("seq0_p2", {21'd0, dut_in}, 32'h004);
        wait_done("seq0_done", 10);
        chk("seq0_pass", {31'd0, pass}, 32'd1);
        tick();

        // dut_out tied 1, two patterns
        dut_out = 1'b1;
        launch(11'h155, 16'd2, 16'h3063);
        chk("ones_sig0", {16'd0, signature}, 32'h0000);
        tick();
        chk("ones_sig1", {16'd0, signature}, 32'h1021);
        tick();
        chk("ones_done", {30'd0, done, pass}, 32'b11);
        chk("ones_sig2", {16'd0, signature}, 32'h3063);
        tick();
        launch(11'h155, 16'd2, 16'h1234);
        wait_done("ones_bad_done", 10);
        chk("ones_bad_pass", {31'd0, pass}, 32'd0);
        chk("ones_bad_sig", {16'd0, signature}, 32'h3063);
        tick();

        // Response alignment: only pattern 0 answers 1
        launch(11'h001, 16'd2, 16'h2042);
        tick();
        dut_out = 1'b0;
        tick();
        chk("align_sig", {16'd0, signature}, 32'h2042);
        chk("align_done", {30'd0, done, pass}, 32'b11);
        tick();

        // 8 patterns of zeros; inputs changed and start pulsed mid-run are ignored
        launch(11'h2AB, 16'd8, 16'h0000);
        pat_count = 16'd3;
        exp_sig   = 16'hFFFF;
        k = 0;
        saw_done = 1'b0;
        while (!saw_done && k < 20) begin
            start = (k == 3);
            tick();
            k++;
            saw_done = done;
        end
        start = 1'b0;
        chk("p8_done_cycle", k, 32'd8);
        chk("p8_result", {15'd0, signature, pass}, {15'd0, 16'h0000, 1'b1});
        tick();

        // Zero patterns
        launch(11'h001, 16'd0, 16'h0001);
        chk("p0_flags", {29'd0, busy, done, pass}, 32'b010);
        chk("p0_sig", {16'd0, signature}, 32'h0000);
        tick();
        chk("p0_after", {29'd0, busy, done}, 32'b00);

        // Abort with start in the same cycle, then a clean rerun
        dut_out = 1'b0;
        launch(11'h001, 16'd10, 16'h0000);
        tick();
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_flags", {29'd0, busy, done, pass}, 32'b000);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        chk("abort_quiet", {31'd0, saw_done}, 32'd0);
        dut_out = 1'b1;
        launch(11'h001, 16'd2, 16'h3063);
        wait_done("abort_rerun_done", 10);
        chk("abort_rerun", {15'd0, signature, pass}, {15'd0, 16'h3063, 1'b1});
        tick();

        // Reset mid-run, then identical restart
        launch(11'h001, 16'd6, 16'hC7BC);
        tick();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {5'd0, busy, done, pass, dut_in, signature[12:0]}, 32'h0);
        chk("midrst_sig", {16'd0, signature}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(11'h001, 16'd6, 16'hC7BC);
        wait_done("midrst_done", 20);
        chk("midrst_result", {15'd0, signature, pass}, {15'd0, 16'hC7BC, 1'b1});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/netlist_bist_ctrl.md
NETLIST_BIST_CTRL -- requirements
Module: netlist_bist_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 11, meaning width of stimulus vector driven into the netlist under test.
REQ-002 SHALL have parameter LAT, default 1, legal 1..4, meaning cycles from stimulus launch to response sample.
REQ-003 SHALL have parameter SIG_W, default 16, meaning signature register width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports, clock and reset first:
  clk        in   1      rising-edge clock
  rst_n      in   1      async active-low reset
  start      in   1      begin a test run (sampled in IDLE only)
  abort      in   1      terminate the run, return to IDLE
  pat_count  in   16     number of patterns to apply
  seed       in   N_IN   stimulus LFSR seed
  exp_sig    in   SIG_W  expected signature
  dut_in     out  N_IN   stimulus to netlist inputs (registered)
  dut_out    in   1      single netlist output (response)
  busy       out  1      high in RUN or DRAIN
  done       out  1      one-cycle completion pulse
  pass       out  1      signature == exp_sig, valid from done onward
  signature  out  SIG_W  accumulated response signature

Function
REQ-006 FSM states SHALL be IDLE, RUN, DRAIN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-007 IDLE with start=1 and abort=0 SHALL, at edge T0: load dut_in with seed (or 1 if seed==0), clear signature to 0, clear pass, enter RUN (or DRAIN if pat_count==1, or DONE if pat_count==0).
REQ-008 Stimulus SHALL be Fibonacci LFSR x^11+x^9+1 (for N_IN=11): dut_in <= {dut_in[N_IN-2:0], dut_in[10]^dut_in[8]}, advancing once per edge in RUN.
REQ-009 Pattern k (k=0..pat_count-1) SHALL be driven on dut_in from edge T0+k; dut_in SHALL hold its last value after the final pattern and in IDLE/DONE.
REQ-010 Response of pattern k SHALL be sampled from dut_out at edge T0+k+LAT, tracked by a LAT-deep valid shift register.
REQ-011 Each sample SHALL update signature as: fb = signature[SIG_W-1] ^ dut_out; signature <= {signature[SIG_W-2:0],0} ^ (fb ? 16'h1021 : 0).
REQ-012 RUN SHALL go to DRAIN after the edge launching the last pattern; DRAIN SHALL go to DONE at the edge capturing the last response (T0+pat_count-1+LAT).
REQ-013 done SHALL be high only in DONE; pass SHALL be set in DONE to (signature==exp_sig) using the final signature, and held with signature until next accepted start.
REQ-014 pat_count==0 SHALL produce DONE in the cycle after T0, signature 0, pass=(exp_sig==0), no samples taken.
REQ-015 busy SHALL be high exactly in RUN and DRAIN.
REQ-016 start SHALL be ignored outside IDLE; pat_count, seed, exp_sig SHALL be captured at T0 and changes during a run ignored.
REQ-017 abort in RUN/DRAIN/DONE SHALL go to IDLE next edge with done=0, pass=0, pending samples discarded, signature frozen; abort wins over start in the same cycle.
REQ-018 pat_count up to 65535 SHALL run without counter overflow; LFSR wrap after 2047 patterns is permitted.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, dut_in=0, signature=0, busy=0, done=0, pass=0, valid pipeline cleared.
REQ-020 Reset asserted mid-run SHALL discard the run; first accepted start after release SHALL behave as from power-up.

Verification
REQ-021 dut_out tied 0, pat_count=8, exp_sig=0 -> done at cycle after T0+8, signature=0x0000, pass=1.
REQ-022 dut_out tied 1, pat_count=2, LAT=1 -> signature 0x1021 after first sample, 0x3063 final, pass=1 iff exp_sig=0x3063.
REQ-023 seed=0x001 -> dut_in sequence 0x001, 0x002, 0x004 ...; seed=0 -> identical sequence.
REQ-024 pat_count=0 with exp_sig=0x0001 -> done one cycle after T0, pass=0, busy never high.
REQ-025 abort at T0+3 of a 10-pattern run, start same cycle -> IDLE, no done pulse, next start runs cleanly.
REQ-026 rst_n low at T0+5, released, restart with same inputs -> signature identical to an uninterrupted run.
